rr_walkingone_arbiter: RTL and testbench
========================================

Name: rr_walkingone_arbiter

Overview:
- Round-robin arbiter that lets up to NUM_REQ units share one resource, for example a memory read port or a result bus.
- It produces a registered walking-one (one-hot) grant vector that drives the select input of the walking-one mux in the datapath.
- The grant is held until the consumer signals completion, or until a watchdog expires.
- A mandatory dead cycle between grants guarantees the mux select never switches directly from one one-hot code to another.

Parameters:
- NUM_REQ, 3, number of requesters; width of the request and grant vectors.
- MAX_HOLD, 16, maximum number of cycles a grant may stay in GRANTED before forced release. 0 disables the watchdog.
- CNT_W, 16, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- Clock  in  1  system clock; all logic on the posedge.
- Reset  in  1  synchronous, active-high reset; one clock, no other clock domains.
- iRequest  in  NUM_REQ  per-requester request level; bit i = requester i.
- iDone  in  1  consumer pulse: the current transaction is complete.
- oGrant  out  NUM_REQ  registered grant, one-hot or all-zero.
- oGrantValid  out  1  high while oGrant is non-zero; equals the OR-reduce of oGrant.
- oBusy  out  1  high in the GRANTED and RELEASE states.
- oTimeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values (next posedge with Reset=1, regardless of current state):
  - state = IDLE, oGrant = 0, oGrantValid = 0, oBusy = 0, oTimeout = 0, hold counter = 0.
  - Priority pointer = one-hot MSB (bit NUM_REQ-1), so bit 0 has top priority after reset.
- States: IDLE, GRANTED, RELEASE.
- IDLE, no request: if iRequest == 0, stay in IDLE with oGrant = 0.
- IDLE, request present:
  - Pick the first set iRequest bit scanning upward from the bit after the pointer, wrapping modulo NUM_REQ.
  - At the next edge: oGrant = winner, pointer = winner, hold counter = 0, state = GRANTED.
  - Request-to-grant latency is 1 cycle.
- GRANTED, grant hold:
  - oGrant is held constant, even if the granted requester drops its request.
  - Other requests are ignored.
  - The hold counter increments every cycle.
- GRANTED, iDone=1: at the next edge oGrant = 0 and state = RELEASE.
- GRANTED, watchdog:
  - Applies when MAX_HOLD != 0, iDone=0 and hold counter == MAX_HOLD-1.
  - At the next edge: oGrant = 0, oTimeout = 1, state = RELEASE.
  - The pointer stays at the timed-out requester.
- GRANTED, simultaneous events: if iDone=1 and the watchdog condition occur in the same cycle, iDone wins and oTimeout stays 0.
- RELEASE:
  - Lasts exactly one cycle with oGrant = 0; then state = IDLE.
  - oTimeout is low at the end of RELEASE.
- iDone while in IDLE or RELEASE is ignored.
- Earliest back-to-back timing: iDone sampled at edge m, RELEASE after edge m, IDLE after m+1, new grant visible after m+2.
- Invariants:
  - oGrant is never multi-hot.
  - oGrant never changes from one non-zero value to another without at least one all-zero cycle in between.
- Hold counter saturates at its maximum value and never wraps.

Test Plan:
- Reset: NUM_REQ=3. Assert Reset for 2 cycles with iRequest=3'b111 -> oGrant=000, oBusy=0 throughout; after deassert, first grant is 3'b001 one cycle later.
- Round-robin fairness: iRequest held at 3'b111, iDone pulsed 2 cycles after each grant -> grant sequence 001, 010, 100, 001, with an all-zero cycle between each pair.
- Request drop while granted: requester 1 granted (010) and drops iRequest before iDone -> oGrant stays 010 until the edge after iDone.
- Watchdog: MAX_HOLD=8, grant 001, no iDone -> oGrant=000 and oTimeout=1 exactly 8 cycles after the grant edge; next winner among 3'b011 is 010.
- Simultaneous events: iDone=1 in the same cycle as the watchdog limit -> release occurs, oTimeout stays 0.
- Mid-transaction reset and sparse/wrap requests:
  - Reset while GRANTED with 100 -> oGrant=000 next edge; the pointer returns to MSB, so iRequest=3'b101 grants 001.
  - With the pointer at 100, iRequest=3'b100 only -> grants 100 again (wrap to self).

Source files
------------

// File: rtl/rr_walkingone_arbiter_if.sv
// rr_walkingone_arbiter_if: request/grant bundle between requesters, consumer and arbiter
// iRequest    per-requester request level
// iDone       consumer completion pulse
// oGrant      registered one-hot (or zero) grant
// oGrantValid OR-reduce of oGrant
// oBusy       arbiter in GRANTED or RELEASE
// oTimeout    one-cycle watchdog release pulse
interface rr_walkingone_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0] iRequest;
  logic               iDone;
  logic [NUM_REQ-1:0] oGrant;
  logic               oGrantValid;
  logic               oBusy;
  logic               oTimeout;
  modport slave (
    input  iRequest, iDone,
    output oGrant, oGrantValid, oBusy, oTimeout
  );
  modport master (
    output iRequest, iDone,
    input  oGrant, oGrantValid, oBusy, oTimeout
  );
endinterface

// File: rtl/rr_walkingone_arbiter.sv
// rr_walkingone_arbiter: round-robin arbiter with held one-hot grant, dead release cycle and hold watchdog
// Clock  system clock, posedge
// Reset  synchronous active-high reset
// bus    slave side of rr_walkingone_arbiter_if (requests, done, grant, status)
module rr_walkingone_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input logic                   Clock,
  input logic                   Reset,
  rr_walkingone_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;
  localparam logic [NUM_REQ-1:0] PTR_RST = NUM_REQ'(1) << (NUM_REQ - 1);
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0] above, req_hi, winner;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d, wd_hit;
  // bits strictly above the pointer get first chance; otherwise wrap to the lowest request
  assign above  = ~(ptr_q | (ptr_q - 1'b1));
  assign req_hi = bus.iRequest & above;
  assign winner = |req_hi ? (req_hi & (~req_hi + 1'b1)) : (bus.iRequest & (~bus.iRequest + 1'b1));
  assign wd_hit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.iRequest) begin
        state_d = GRANTED;
        grant_d = winner;
        ptr_d   = winner;
        cnt_d   = '0;
      end
      GRANTED: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (bus.iDone || wd_hit) begin
          state_d   = RELEASE;
          grant_d   = '0;
          timeout_d = !bus.iDone;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.oGrant      = grant_q;
  assign bus.oGrantValid = |grant_q;
  assign bus.oBusy       = state_q != IDLE;
  assign bus.oTimeout    = timeout_q;
endmodule

// File: tb/tb_rr_walkingone_arbiter.sv
// tb_rr_walkingone_arbiter: directed vector bench for the round-robin walking-one arbiter
module tb_rr_walkingone_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  rr_walkingone_arbiter_if #(.NUM_REQ(3)) bus ();
  rr_walkingone_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .CNT_W(16)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       r;
    logic [2:0] req;
    logic       done;
    logic [2:0] g;
    logic       t;
    logic       b;
  } vec_t;
  vec_t tv [35];
  task automatic step(input logic r, input logic [2:0] req, input logic done,
                      input logic [2:0] g, input logic t, input logic b, input string name);
    logic [5:0] act, exp;
    @(negedge clk);
    rst          = r;
    bus.iRequest = req;
    bus.iDone    = done;
    @(posedge clk);
    #1;
    act = {bus.oGrant, bus.oGrantValid, bus.oBusy, bus.oTimeout};
    exp = {g, |g, b, t};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got grant/valid/busy/timeout=%b, expected %b", name, act, exp);
    end
    checks++;
    if (!$onehot0(bus.oGrant)) begin
      errors++;
      $display("FAIL %s_onehot: grant=%b, expected one-hot or zero", name, bus.oGrant);
    end
  endtask
  initial begin
    bus.iRequest = 3'b111;
    bus.iDone    = 1'b0;
    tv[0]  = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[10] = '{1'b0, 3'b111, 1'b0, 3'b100, 1'b0, 1'b1};
    tv[11] = '{1'b0, 3'b111, 1'b0, 3'b100, 1'b0, 1'b1};
    tv[12] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[13] = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[14] = '{1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1};
    tv[15] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[16] = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[17] = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1};
    tv[18] = '{1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1};
    tv[19] = '{1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1};
    tv[20] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[21] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[22] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[23] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
    tv[24] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1};
    tv[25] = '{1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[26] = '{1'b0, 3'b101, 1'b0, 3'b001, 1'b0, 1'b1};
    tv[27] = '{1'b0, 3'b101, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[28] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[29] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1};
    tv[30] = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[31] = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b0};
    tv[32] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1};
    tv[33] = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[34] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    for (int i = 0; i < 35; i++)
      step(tv[i].r, tv[i].req, tv[i].done, tv[i].g, tv[i].t, tv[i].b, $sformatf("vec%0d", i));
    step(1'b0, 3'b011, 1'b0, 3'b001, 1'b0, 1'b1, "wd_grant");
    for (int i = 1; i < 8; i++)
      step(1'b0, 3'b011, 1'b0, 3'b001, 1'b0, 1'b1, $sformatf("wd_hold%0d", i));
    step(1'b0, 3'b011, 1'b0, 3'b000, 1'b1, 1'b1, "wd_fire");
    step(1'b0, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, "wd_release");
    step(1'b0, 3'b011, 1'b0, 3'b010, 1'b0, 1'b1, "wd_next");
    for (int i = 1; i < 8; i++)
      step(1'b0, 3'b011, 1'b0, 3'b010, 1'b0, 1'b1, $sformatf("sim_hold%0d", i));
    step(1'b0, 3'b011, 1'b1, 3'b000, 1'b0, 1'b1, "sim_done");
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "sim_release");
    step(1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "sim_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
